// File: rtl/alu_op_sequencer.sv
// Registered command front-end for the 8-bit 4-op ALU: one op in flight, programmable settle time.
// Optional result chaining (previous rsp_data[7:0] as operand A) is enabled by ALU_SEQ_CHAIN_EN.
module alu_op_sequencer #(
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [1:0]       i_cmd_op,
  input  logic [7:0]       i_cmd_a,
  input  logic [7:0]       i_cmd_b,
  input  logic             i_cmd_chain,
  output logic [7:0]       o_alu_a,
  output logic [7:0]       o_alu_b,
  output logic [1:0]       o_alu_op,
  input  logic [8:0]       i_alu_out,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [8:0]       o_rsp_data,
  output logic             o_rsp_carry,
  output logic             o_rsp_zero,
  output logic [CNT_W-1:0] o_op_count
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

  state_e           r_state, w_state_d;
  logic             r_cmd_ready;
  logic [3:0]       r_wait;
  logic [7:0]       r_alu_a, r_alu_b;
  logic [1:0]       r_alu_op;
  logic             r_rsp_valid;
  logic [8:0]       r_rsp_data;
  logic             r_rsp_carry, r_rsp_zero;
  logic [CNT_W-1:0] r_op_count;
  logic             w_accept, w_capture, w_rsp_hs;
  logic [7:0]       w_a_sel;

  always_comb begin
    w_state_d = r_state;
    w_accept  = 1'b0;
    w_capture = 1'b0;
    w_rsp_hs  = 1'b0;
    case (r_state)
      StIdle: begin
        w_accept = i_cmd_valid && r_cmd_ready;
        if (w_accept) w_state_d = StExec;
      end
      StExec: begin
        w_capture = (r_wait == 4'd0);
        if (w_capture) w_state_d = StResp;
      end
      StResp: begin
        w_rsp_hs = i_rsp_ready;
        if (w_rsp_hs) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_cmd_ready <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      // Registered so ready stays low while reset is held and rises on the first clock after.
      r_cmd_ready <= (w_state_d == StIdle);
    end
  end

`ifdef ALU_SEQ_CHAIN_EN
  logic [7:0] r_chain;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_chain <= 8'h00;
    end else if (w_rsp_hs) begin
      r_chain <= r_rsp_data[7:0];
    end
  end

  assign w_a_sel = i_cmd_chain ? r_chain : i_cmd_a;
`else
  logic w_unused_chain;
  assign w_unused_chain = i_cmd_chain;
  assign w_a_sel        = i_cmd_a;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wait      <= 4'd0;
      r_alu_a     <= 8'h00;
      r_alu_b     <= 8'h00;
      r_alu_op    <= 2'b00;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 9'h000;
      r_rsp_carry <= 1'b0;
      r_rsp_zero  <= 1'b0;
      r_op_count  <= '0;
    end else begin
      if (w_accept) begin
        r_alu_a  <= w_a_sel;
        r_alu_b  <= i_cmd_b;
        r_alu_op <= i_cmd_op;
        r_wait   <= LP_WAIT;
      end else if (r_state == StExec && !w_capture) begin
        r_wait <= r_wait - 4'd1;
      end
      if (w_capture) begin
        r_rsp_valid <= 1'b1;
        r_rsp_data  <= i_alu_out;
        r_rsp_carry <= i_alu_out[8];
        r_rsp_zero  <= (i_alu_out == 9'h000);
      end
      if (w_rsp_hs) begin
        r_rsp_valid <= 1'b0;
        r_op_count  <= r_op_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign o_cmd_ready = r_cmd_ready;
  assign o_alu_a     = r_alu_a;
  assign o_alu_b     = r_alu_b;
  assign o_alu_op    = r_alu_op;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_carry = r_rsp_carry;
  assign o_rsp_zero  = r_rsp_zero;
  assign o_op_count  = r_op_count;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: WAIT_CYCLES=0 instance for function/backpressure/reset/chain,
// WAIT_CYCLES=3 instance for settle-time capture. Chain expectations follow ALU_SEQ_CHAIN_EN.
module tb_alu_op_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Instance 0 (WAIT_CYCLES=0)
  logic        cmd_valid = 1'b0, cmd_chain = 1'b0, rsp_ready = 1'b0;
  logic [1:0]  cmd_op = 2'b00;
  logic [7:0]  cmd_a = 8'h00, cmd_b = 8'h00;
  logic        cmd_ready, rsp_valid, rsp_carry, rsp_zero;
  logic [7:0]  alu_a, alu_b;
  logic [1:0]  alu_op;
  logic [8:0]  alu_out, rsp_data;
  logic [15:0] op_count;

  // Instance 1 (WAIT_CYCLES=3)
  logic        w3_cmd_valid = 1'b0, w3_rsp_ready = 1'b0;
  logic [1:0]  w3_cmd_op = 2'b00;
  logic [7:0]  w3_cmd_a = 8'h00, w3_cmd_b = 8'h00;
  logic        w3_cmd_ready, w3_rsp_valid, w3_rsp_carry, w3_rsp_zero;
  logic [7:0]  w3_alu_a, w3_alu_b;
  logic [1:0]  w3_alu_op;
  logic [8:0]  w3_alu_out, w3_rsp_data;
  logic [15:0] w3_op_count;
  logic        ovr_en = 1'b0;
  logic [8:0]  ovr_val = 9'h000;

  // Reference ALU: add, sub (bit8 = borrow), xor, shl1 (bit8 = 0)
  function automatic logic [8:0] alu_f(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      2'b00:   alu_f = {1'b0, a} + {1'b0, b};
      2'b01:   alu_f = {1'b0, a} - {1'b0, b};
      2'b10:   alu_f = {1'b0, a ^ b};
      default: alu_f = {1'b0, a[6:0], 1'b0};
    endcase
  endfunction

  assign alu_out    = alu_f(alu_op, alu_a, alu_b);
  assign w3_alu_out = ovr_en ? ovr_val : alu_f(w3_alu_op, w3_alu_a, w3_alu_b);

  alu_op_sequencer #(.WAIT_CYCLES(0), .CNT_W(16)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_op(cmd_op), .i_cmd_a(cmd_a), .i_cmd_b(cmd_b), .i_cmd_chain(cmd_chain),
    .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_op(alu_op), .i_alu_out(alu_out),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_data(rsp_data),
    .o_rsp_carry(rsp_carry), .o_rsp_zero(rsp_zero), .o_op_count(op_count)
  );

  alu_op_sequencer #(.WAIT_CYCLES(3), .CNT_W(16)) u_dut_w3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_cmd_valid(w3_cmd_valid), .o_cmd_ready(w3_cmd_ready),
    .i_cmd_op(w3_cmd_op), .i_cmd_a(w3_cmd_a), .i_cmd_b(w3_cmd_b), .i_cmd_chain(1'b0),
    .o_alu_a(w3_alu_a), .o_alu_b(w3_alu_b), .o_alu_op(w3_alu_op), .i_alu_out(w3_alu_out),
    .o_rsp_valid(w3_rsp_valid), .i_rsp_ready(w3_rsp_ready), .o_rsp_data(w3_rsp_data),
    .o_rsp_carry(w3_rsp_carry), .o_rsp_zero(w3_rsp_zero), .o_op_count(w3_op_count)
  );

  // All tasks start and end 1ns after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic ch);
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_chain = ch; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0; cmd_chain = 1'b0;
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL reset_cmd_ready got %b exp 0", cmd_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
    checks++; if ({alu_a, alu_b, alu_op} !== 18'h0) begin failures++; $display("FAIL reset_alu got %h exp 0", {alu_a, alu_b, alu_op}); end
    checks++; if ({rsp_data, rsp_carry, rsp_zero} !== 11'h0) begin failures++; $display("FAIL reset_rsp got %h exp 0", {rsp_data, rsp_carry, rsp_zero}); end
    checks++; if (op_count !== 16'h0) begin failures++; $display("FAIL reset_op_count got %h exp 0", op_count); end
    #2 rst_n = 1'b1;
    step();
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL post_reset_cmd_ready got %b exp 1", cmd_ready); end
  endtask

  task automatic test_add();
    send(2'b00, 8'h80, 8'h80, 1'b0);
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL add_early_valid got %b exp 0", rsp_valid); end
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL add_exec_ready got %b exp 0", cmd_ready); end
    step();
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL add_latency got %b exp 1", rsp_valid); end
    checks++; if (rsp_data !== 9'h100) begin failures++; $display("FAIL add_data got %h exp 100", rsp_data); end
    checks++; if ({rsp_carry, rsp_zero} !== 2'b10) begin failures++; $display("FAIL add_flags got %b exp 10", {rsp_carry, rsp_zero}); end
    checks++; if (op_count !== 16'd0) begin failures++; $display("FAIL add_count_before got %0d exp 0", op_count); end
    release_rsp();
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL add_valid_clear got %b exp 0", rsp_valid); end
    checks++; if (op_count !== 16'd1) begin failures++; $display("FAIL add_count_after got %0d exp 1", op_count); end
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL add_ready_after got %b exp 1", cmd_ready); end
  endtask

  task automatic test_ops();
    logic [1:0] t_op[3] = '{2'b01, 2'b10, 2'b11};
    logic [7:0] t_a[3]  = '{8'h05, 8'hAA, 8'hC3};
    logic [7:0] t_b[3]  = '{8'h07, 8'hAA, 8'h00};
    logic [8:0] t_d[3]  = '{9'h1FE, 9'h000, 9'h086};
    logic [1:0] t_f[3]  = '{2'b10, 2'b01, 2'b00};
    bit ok;
    for (int i = 0; i < 3; i++) begin
      send(t_op[i], t_a[i], t_b[i], 1'b0);
      wait_rsp(ok);
      checks++; if (!ok) begin failures++; $display("FAIL ops%0d_timeout got no rsp_valid exp rsp_valid", i); end
      checks++; if (rsp_data !== t_d[i]) begin failures++; $display("FAIL ops%0d_data got %h exp %h", i, rsp_data, t_d[i]); end
      checks++; if ({rsp_carry, rsp_zero} !== t_f[i]) begin failures++; $display("FAIL ops%0d_flags got %b exp %b", i, {rsp_carry, rsp_zero}, t_f[i]); end
      release_rsp();
    end
    checks++; if (op_count !== 16'd4) begin failures++; $display("FAIL ops_count got %0d exp 4", op_count); end
  endtask

  task automatic test_backpressure();
    bit ok;
    send(2'b00, 8'h01, 8'h02, 1'b0);
    wait_rsp(ok);
    checks++; if (!ok) begin failures++; $display("FAIL bp_timeout got no rsp_valid exp rsp_valid"); end
    for (int i = 0; i < 5; i++) begin
      cmd_valid = (i == 2); cmd_op = 2'b10; cmd_a = 8'h5A; cmd_b = 8'h33;
      step();
      checks++; if ({rsp_valid, cmd_ready} !== 2'b10) begin failures++; $display("FAIL bp_hs%0d got %b exp 10", i, {rsp_valid, cmd_ready}); end
      checks++; if ({rsp_data, rsp_carry, rsp_zero} !== {9'h003, 2'b00}) begin failures++; $display("FAIL bp_rsp%0d got %h exp %h", i, {rsp_data, rsp_carry, rsp_zero}, {9'h003, 2'b00}); end
      checks++; if ({alu_a, alu_b, alu_op} !== {8'h01, 8'h02, 2'b00}) begin failures++; $display("FAIL bp_alu%0d got %h exp %h", i, {alu_a, alu_b, alu_op}, {8'h01, 8'h02, 2'b00}); end
    end
    cmd_valid = 1'b0;
    release_rsp();
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_after got %b exp 1", cmd_ready); end
    checks++; if (op_count !== 16'd5) begin failures++; $display("FAIL bp_count got %0d exp 5", op_count); end
    step();
    checks++; if ({rsp_valid, alu_a} !== {1'b0, 8'h01}) begin failures++; $display("FAIL bp_idle_hold got %h exp %h", {rsp_valid, alu_a}, {1'b0, 8'h01}); end
  endtask

  task automatic test_wait_cycles();
    w3_cmd_op = 2'b00; w3_cmd_a = 8'h12; w3_cmd_b = 8'h34; w3_cmd_valid = 1'b1;
    step();  // edge k
    w3_cmd_valid = 1'b0;
    ovr_en = 1'b1; ovr_val = 9'h1FF;
    for (int i = 1; i <= 3; i++) begin
      step();  // edge k+i
      checks++; if (w3_rsp_valid !== 1'b0) begin failures++; $display("FAIL w3_early_valid_k%0d got %b exp 0", i, w3_rsp_valid); end
    end
    ovr_en = 1'b0;
    step();  // edge k+4
    checks++; if (w3_rsp_valid !== 1'b1) begin failures++; $display("FAIL w3_valid_k4 got %b exp 1", w3_rsp_valid); end
    checks++; if (w3_rsp_data !== 9'h046) begin failures++; $display("FAIL w3_data got %h exp 046", w3_rsp_data); end
    w3_rsp_ready = 1'b1;
    step();
    w3_rsp_ready = 1'b0;
    checks++; if ({w3_rsp_valid, w3_op_count} !== {1'b0, 16'd1}) begin failures++; $display("FAIL w3_done got %h exp %h", {w3_rsp_valid, w3_op_count}, {1'b0, 16'd1}); end
  endtask

  task automatic test_reset_mid();
    send(2'b00, 8'h80, 8'h80, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({cmd_ready, rsp_valid} !== 2'b00) begin failures++; $display("FAIL mid_rst_hs got %b exp 00", {cmd_ready, rsp_valid}); end
    checks++; if ({alu_a, alu_b, alu_op, rsp_data, rsp_carry, rsp_zero} !== 29'h0) begin failures++; $display("FAIL mid_rst_data got %h exp 0", {alu_a, alu_b, alu_op, rsp_data, rsp_carry, rsp_zero}); end
    checks++; if (op_count !== 16'd0) begin failures++; $display("FAIL mid_rst_count got %0d exp 0", op_count); end
    step();
    #3 rst_n = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_no_rsp%0d got %b exp 0", i, rsp_valid); end
      step();
    end
    checks++; if ({cmd_ready, op_count} !== {1'b1, 16'd0}) begin failures++; $display("FAIL mid_rst_after got %h exp %h", {cmd_ready, op_count}, {1'b1, 16'd0}); end
  endtask

  task automatic test_chain();
    bit ok;
    logic [7:0] exp_a;
    logic [8:0] exp_d;
`ifdef ALU_SEQ_CHAIN_EN
    exp_a = 8'h30; exp_d = 9'h031;
`else
    exp_a = 8'hFF; exp_d = 9'h100;
`endif
    send(2'b00, 8'h10, 8'h20, 1'b0);
    wait_rsp(ok);
    checks++; if (rsp_data !== 9'h030 || !ok) begin failures++; $display("FAIL chain_first got %h exp 030", rsp_data); end
    release_rsp();
    send(2'b00, 8'hFF, 8'h01, 1'b1);
    wait_rsp(ok);
    checks++; if (!ok) begin failures++; $display("FAIL chain_timeout got no rsp_valid exp rsp_valid"); end
    checks++; if (alu_a !== exp_a) begin failures++; $display("FAIL chain_alu_a got %h exp %h", alu_a, exp_a); end
    checks++; if (rsp_data !== exp_d) begin failures++; $display("FAIL chain_data got %h exp %h", rsp_data, exp_d); end
    release_rsp();
  endtask

  initial begin
    test_reset();
    test_add();
    test_ops();
    test_backpressure();
    test_wait_cycles();
    test_reset_mid();
    test_chain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Registered command front-end that drives the team's 8-bit, 4-op combinational ALU (add, sub, xor, shift-left-1; 9-bit result) from the initiator side. It accepts one operation per valid/ready handshake and presents operands/opcode to the ALU from registers. It captures the 9-bit ALU result after a programmable settle time and returns it with flags on a valid/ready response channel. One operation is outstanding at a time; it sits between a control FSM/testbench master and the ALU instance.

Parameters:
WAIT_CYCLES, 0, extra ALU settle cycles before result capture (0..15)
CNT_W, 16, width of completed-operation counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command request
cmd_ready  output  1  sequencer can accept command
cmd_op  input  2  00 add, 01 sub, 10 xor, 11 shl1
cmd_a  input  8  operand A
cmd_b  input  8  operand B
cmd_chain  input  1  use previous result[7:0] as A (see Optional Feature)
alu_a  output  8  registered operand A to ALU
alu_b  output  8  registered operand B to ALU
alu_op  output  2  registered opcode to ALU
alu_out  input  9  ALU result
rsp_valid  output  1  result available
rsp_ready  input  1  consumer accepts result
rsp_data  output  9  captured ALU result
rsp_carry  output  1  rsp_data[8]
rsp_zero  output  1  rsp_data == 9'h000
op_count  output  CNT_W  completed (handshaken) responses

Behaviour:
- Reset (async, rst_n=0): state IDLE; cmd_ready=0 while in reset, 1 in the first IDLE cycle after release; alu_a/alu_b/alu_op=0; rsp_valid=0; rsp_data=0; rsp_carry=0; rsp_zero=0 (registered flags); op_count=0; wait counter=0; chain register=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready at edge k: load alu_a/alu_b/alu_op, load wait counter with WAIT_CYCLES, go EXEC.
- EXEC: cmd_ready=0. If counter!=0, decrement. If counter==0, capture alu_out into rsp_data, register flags, set rsp_valid, go RESP. Capture occurs at edge k+1+WAIT_CYCLES. rsp_valid is high from that edge, with minimum latency 2 cycles from accept to rsp_valid sampled high.
- RESP: rsp_valid=1; rsp_data/flags/alu_* held stable. On rsp_ready: clear rsp_valid, increment op_count (wraps modulo 2^CNT_W), store rsp_data[7:0] into chain register, go IDLE. cmd_ready is 0 throughout RESP, so there is no same-cycle response/accept overlap.
- The sequencer performs no arithmetic. rsp_data equals the ALU result for the registered operands:
  - add: 9-bit sum.
  - sub: A-B modulo 2^9, bit8 = borrow.
  - xor and shl1: bit8 = 0.
- Flags are computed from the captured value, not from live alu_out.
- cmd_* inputs are ignored outside IDLE. rsp_ready is ignored outside RESP.
- Reset asserted in any state aborts the operation immediately. No response is produced and op_count is cleared.
- alu_* outputs hold their last values in IDLE; they are not cleared after a response.

Optional Feature:
- Macro: ALU_SEQ_CHAIN_EN.
- Defined: when cmd_chain=1 at accept, alu_a loads the chain register (previous response rsp_data[7:0]) instead of cmd_a. This lets accumulate sequences run without the master tracking results. The chain register is 0 after reset.
- Undefined: cmd_chain is ignored, alu_a always loads cmd_a, and the chain register is not implemented.

Test Plan:
- WAIT_CYCLES=0: accept add A=8'h80 B=8'h80 -> rsp_valid high 2 cycles later; rsp_data=9'h100, rsp_carry=1, rsp_zero=0; op_count 0->1 on rsp_ready.
- Sub A=8'h05 B=8'h07 -> rsp_data=9'h1FE, carry=1. xor A=8'hAA B=8'hAA -> rsp_data=0, zero=1. shl1 A=8'hC3 -> rsp_data=9'h086, carry=0.
- Backpressure: rsp_ready low for 5 cycles after rsp_valid -> rsp_data/flags/alu_* stable, cmd_ready=0, a cmd_valid pulse is not accepted; rsp_ready high -> IDLE, cmd_ready=1 next cycle.
- WAIT_CYCLES=3: accept at edge k -> capture at edge k+4; changing alu_out before edge k+4 is not reflected.
- Reset mid-EXEC (rst_n low, asynchronously, between edges) -> all outputs 0 immediately, no rsp_valid after release, op_count=0.
- ALU_SEQ_CHAIN_EN defined: add 8'h10+8'h20 -> 9'h030; then chain add cmd_a=8'hFF cmd_b=8'h01 -> alu_a=8'h30, rsp_data=9'h031. Macro undefined: same stimulus -> rsp_data=9'h100.
